// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// Tracks producers in E and M and registers the execute-stage operand selects.
module fwd_hazard_unit #(
    parameter int NREG_BITS = 5,
    parameter int SEL_W     = 3
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic [NREG_BITS-1:0] i_addr_Drs,
    input  logic [NREG_BITS-1:0] i_addr_Drt,
    input  logic [NREG_BITS-1:0] i_addr_Ddst,
    input  logic                 i_con_Dvalid,
    input  logic                 i_con_Dusers,
    input  logic                 i_con_Dusert,
    input  logic                 i_con_Dregwrite,
    input  logic                 i_con_Dmemread,
    input  logic                 i_con_freeze,
    output logic [SEL_W-1:0]     o_con_Efamux,
    output logic [SEL_W-1:0]     o_con_Efbmux,
    output logic                 o_con_stallF,
    output logic                 o_con_stallD,
    output logic                 o_con_flushE
);

    localparam logic [SEL_W-1:0] SEL_RF     = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_FE_ALU = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_FM_ALU = SEL_W'(2);
    localparam logic [SEL_W-1:0] SEL_FM_MEM = SEL_W'(3);

    // The register file writes through, so a producer in W is already visible
    // to D; only the E and M producers need tracking.
    logic [NREG_BITS-1:0] r_e_dst, r_m_dst;
    logic                 r_e_rw, r_e_mr, r_m_rw, r_m_mr;
    logic [SEL_W-1:0]     r_fa, r_fb;

    logic [NREG_BITS-1:0] w_src [2];
    logic [1:0]           w_use;
    logic [1:0]           w_load_use;
    logic [SEL_W-1:0]     w_code [2];
    logic                 w_hazard;
    logic                 w_stall;

    assign w_src[0] = i_addr_Drs;
    assign w_src[1] = i_addr_Drt;
    assign w_use    = {i_con_Dusert, i_con_Dusers};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
            logic w_hit_e, w_hit_m;
            assign w_hit_e = w_use[gi] & r_e_rw & (r_e_dst == w_src[gi]) & (w_src[gi] != '0);
            assign w_hit_m = w_use[gi] & r_m_rw & (r_m_dst == w_src[gi]) & (w_src[gi] != '0);
            // Nearest producer wins; a load in E cannot forward and forces a stall.
            assign w_load_use[gi] = w_hit_e & r_e_mr;
            assign w_code[gi] = w_hit_e ? (r_e_mr ? SEL_RF : SEL_FE_ALU)
                              : w_hit_m ? (r_m_mr ? SEL_FM_MEM : SEL_FM_ALU)
                              : SEL_RF;
        end
    endgenerate

    assign w_hazard = i_con_Dvalid & (|w_load_use);
    assign w_stall  = w_hazard & ~i_con_freeze;

    assign o_con_stallF = w_stall;
    assign o_con_stallD = w_stall;
    assign o_con_flushE = w_stall;
    assign o_con_Efamux = r_fa;
    assign o_con_Efbmux = r_fb;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_e_dst <= '0;
            r_e_rw  <= 1'b0;
            r_e_mr  <= 1'b0;
            r_m_dst <= '0;
            r_m_rw  <= 1'b0;
            r_m_mr  <= 1'b0;
            r_fa    <= SEL_RF;
            r_fb    <= SEL_RF;
        end else if (!i_con_freeze) begin
            r_m_dst <= r_e_dst;
            r_m_rw  <= r_e_rw;
            r_m_mr  <= r_e_mr;
            if (w_hazard) begin
                r_e_dst <= '0;
                r_e_rw  <= 1'b0;
                r_e_mr  <= 1'b0;
                r_fa    <= SEL_RF;
                r_fb    <= SEL_RF;
            end else begin
                r_e_dst <= i_addr_Ddst;
                r_e_rw  <= i_con_Dregwrite & i_con_Dvalid;
                r_e_mr  <= i_con_Dmemread & i_con_Dvalid;
                r_fa    <= i_con_Dvalid ? w_code[0] : SEL_RF;
                r_fb    <= i_con_Dvalid ? w_code[1] : SEL_RF;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Randomized and directed bench for fwd_hazard_unit against a producer-history
// reference model that searches the in-flight instructions by distance.
module tb_fwd_hazard_unit;

    logic       i_clk = 1'b0;
    logic       i_nrst;
    logic [4:0] i_addr_Drs, i_addr_Drt, i_addr_Ddst;
    logic       i_con_Dvalid, i_con_Dusers, i_con_Dusert;
    logic       i_con_Dregwrite, i_con_Dmemread, i_con_freeze;
    logic [2:0] o_con_Efamux, o_con_Efbmux;
    logic       o_con_stallF, o_con_stallD, o_con_flushE;

    fwd_hazard_unit dut (
        .i_clk(i_clk), .i_nrst(i_nrst),
        .i_addr_Drs(i_addr_Drs), .i_addr_Drt(i_addr_Drt), .i_addr_Ddst(i_addr_Ddst),
        .i_con_Dvalid(i_con_Dvalid), .i_con_Dusers(i_con_Dusers), .i_con_Dusert(i_con_Dusert),
        .i_con_Dregwrite(i_con_Dregwrite), .i_con_Dmemread(i_con_Dmemread),
        .i_con_freeze(i_con_freeze),
        .o_con_Efamux(o_con_Efamux), .o_con_Efbmux(o_con_Efbmux),
        .o_con_stallF(o_con_stallF), .o_con_stallD(o_con_stallD), .o_con_flushE(o_con_flushE)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: producers at distance 1 (in E) and 2 (in M), plus the
    // selects expected for whatever currently sits in E.
    logic [4:0] m_dst [1:2];
    logic       m_rw  [1:2];
    logic       m_ld  [1:2];
    int         m_fa, m_fb;
    bit         last_stall;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int d = 1; d <= 2; d++) begin
            m_dst[d] = '0; m_rw[d] = 1'b0; m_ld[d] = 1'b0;
        end
        m_fa = 0; m_fb = 0;
    endtask

    // Look back through in-flight producers, nearest first.
    function automatic void lookup(input logic [4:0] x, input logic used,
                                   output int code, output bit lu);
        code = 0; lu = 1'b0;
        if (used && x != 5'd0) begin
            for (int d = 1; d <= 2; d++) begin
                if (m_rw[d] && m_dst[d] == x) begin
                    if (d == 1) begin
                        if (m_ld[d]) lu = 1'b1; else code = 1;
                    end else begin
                        code = m_ld[d] ? 3 : 2;
                    end
                    break;
                end
            end
        end
    endfunction

    task automatic step(input logic [4:0] dst, input logic [4:0] rs, input logic [4:0] rt,
                        input logic v, input logic urs, input logic urt,
                        input logic rw, input logic ld, input logic frz);
        int  ca, cb;
        bit  la, lb, hz, exp_stall;
        @(negedge i_clk);
        i_addr_Ddst = dst; i_addr_Drs = rs; i_addr_Drt = rt;
        i_con_Dvalid = v; i_con_Dusers = urs; i_con_Dusert = urt;
        i_con_Dregwrite = rw; i_con_Dmemread = ld; i_con_freeze = frz;
        #1;
        lookup(rs, urs, ca, la);
        lookup(rt, urt, cb, lb);
        hz = v && (la || lb);
        exp_stall = hz && !frz;
        check("stallF", int'(o_con_stallF), int'(exp_stall));
        check("stallD", int'(o_con_stallD), int'(exp_stall));
        check("flushE", int'(o_con_flushE), int'(exp_stall));
        check("fa", int'(o_con_Efamux), m_fa);
        check("fb", int'(o_con_Efbmux), m_fb);
        last_stall = exp_stall;
        @(posedge i_clk);
        if (!frz) begin
            m_dst[2] = m_dst[1]; m_rw[2] = m_rw[1]; m_ld[2] = m_ld[1];
            if (hz) begin
                m_dst[1] = '0; m_rw[1] = 1'b0; m_ld[1] = 1'b0;
                m_fa = 0; m_fb = 0;
            end else begin
                m_dst[1] = dst; m_rw[1] = rw & v; m_ld[1] = ld & v;
                m_fa = v ? ca : 0;
                m_fb = v ? cb : 0;
            end
        end
    endtask

    // Issue one valid instruction, re-presenting it while the unit stalls.
    task automatic issue(input logic [4:0] dst, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic rw, input logic ld);
        int tries = 0;
        do begin
            step(dst, rs, rt, 1'b1, urs, urt, rw, ld, 1'b0);
            tries++;
        end while (last_stall && tries < 4);
        if (last_stall) check("stall_bound", tries, 1);
    endtask

    task automatic nop();
        step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_sel(input string tag, input int fa, input int fb);
        #1;
        check({tag, "_fa"}, int'(o_con_Efamux), fa);
        check({tag, "_fb"}, int'(o_con_Efbmux), fb);
    endtask

    logic [4:0] r_dst, r_rs, r_rt;
    logic       r_v, r_urs, r_urt, r_rw, r_ld;

    initial begin
        i_nrst = 1'b0;
        i_addr_Drs = '0; i_addr_Drt = '0; i_addr_Ddst = '0;
        i_con_Dvalid = 0; i_con_Dusers = 0; i_con_Dusert = 0;
        i_con_Dregwrite = 0; i_con_Dmemread = 0; i_con_freeze = 0;
        model_reset();
        last_stall = 1'b0;
        #12;
        check("rst_fa", int'(o_con_Efamux), 0);
        check("rst_fb", int'(o_con_Efbmux), 0);
        check("rst_stall", int'(o_con_stallF), 0);
        @(negedge i_clk);
        i_nrst = 1'b1;

        // Back-to-back ALU: add $3 then sub $4 <- $3,$3
        issue(5'd3, 5'd1, 5'd2, 1, 1, 1, 0);
        issue(5'd4, 5'd3, 5'd3, 1, 1, 1, 0);
        expect_sel("b2b", 1, 1);
        // Distance-2 ALU: add $5, nop, or reads $5 as rs
        issue(5'd5, 5'd1, 5'd2, 1, 1, 1, 0);
        nop();
        issue(5'd9, 5'd5, 5'd1, 1, 1, 1, 0);
        expect_sel("dist2", 2, 0);
        // Load-use: lw $6 then add reads $6 as rt
        issue(5'd6, 5'd1, 5'd0, 1, 0, 1, 1);
        step(5'd10, 5'd1, 5'd6, 1, 1, 1, 1, 0, 0);
        check("lu_stall", int'(last_stall), 1);
        expect_sel("lu_bubble", 0, 0);
        step(5'd10, 5'd1, 5'd6, 1, 1, 1, 1, 0, 0);
        check("lu_release", int'(last_stall), 0);
        expect_sel("lu_fwd", 0, 3);
        // Priority: add $7, lw $7, use $7
        issue(5'd7, 5'd1, 5'd2, 1, 1, 1, 0);
        issue(5'd7, 5'd1, 5'd0, 1, 0, 1, 1);
        issue(5'd11, 5'd7, 5'd0, 1, 0, 1, 0);
        expect_sel("prio", 3, 0);
        // $0 writer never forwards
        issue(5'd0, 5'd1, 5'd0, 1, 0, 1, 0);
        issue(5'd12, 5'd0, 5'd0, 1, 1, 1, 0);
        expect_sel("zero", 0, 0);
        // Freeze over a pending load-use hazard
        issue(5'd8, 5'd1, 5'd0, 1, 0, 1, 1);
        step(5'd13, 5'd8, 5'd0, 1, 1, 0, 1, 0, 1);
        check("frz_nostall", int'(last_stall), 0);
        step(5'd13, 5'd8, 5'd0, 1, 1, 0, 1, 0, 1);
        step(5'd13, 5'd8, 5'd0, 1, 1, 0, 1, 0, 0);
        check("frz_after", int'(last_stall), 1);
        issue(5'd13, 5'd8, 5'd0, 1, 0, 1, 0);
        expect_sel("frz_fwd", 3, 0);
        // Async reset during a stall
        issue(5'd14, 5'd1, 5'd0, 1, 0, 1, 1);
        @(negedge i_clk);
        i_addr_Ddst = 5'd15; i_addr_Drs = 5'd14; i_addr_Drt = 5'd0;
        i_con_Dvalid = 1; i_con_Dusers = 1; i_con_Dusert = 0;
        i_con_Dregwrite = 1; i_con_Dmemread = 0; i_con_freeze = 0;
        #1;
        check("pre_rst_stall", int'(o_con_stallF), 1);
        i_nrst = 1'b0;
        #1;
        check("arst_stallF", int'(o_con_stallF), 0);
        check("arst_flushE", int'(o_con_flushE), 0);
        check("arst_fa", int'(o_con_Efamux), 0);
        model_reset();
        @(negedge i_clk);
        i_nrst = 1'b1;
        issue(5'd15, 5'd14, 5'd14, 1, 1, 1, 0);
        expect_sel("post_rst", 0, 0);

        // Randomized traffic over a small register set to provoke hits
        last_stall = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!last_stall) begin
                r_dst = 5'($urandom_range(0, 3));
                r_rs  = 5'($urandom_range(0, 3));
                r_rt  = 5'($urandom_range(0, 3));
                r_v   = ($urandom % 8) != 0;
                r_urs = ($urandom % 4) != 0;
                r_urt = ($urandom % 2) != 0;
                r_rw  = ($urandom % 4) != 0;
                r_ld  = r_rw && (($urandom % 3) == 0);
            end
            step(r_dst, r_rs, r_rt, r_v, r_urs, r_urt, r_rw, r_ld, ($urandom % 8) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
